button_conditioner: RTL and testbench

Input-side counterpart to the seven-segment output path. It turns raw, asynchronous, bouncing pushbuttons (startstop, increment, reset) into clean per-button events for the stopwatch core. For each button it produces a debounced level, a single-cycle press pulse, a single-cycle release pulse, a long-press flag and optional auto-repeat press pulses. All buttons are handled independently and identically.

---
 rtl/button_conditioner.sv | 163 ++++++++++++++++
 tb/tb_button_conditioner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-flop synchronizer plus a per-button debounce FSM that
// produces a clean level, press/release pulses, a long-press flag and auto-repeat.
module button_conditioner #(
  parameter int NUM_BTN       = 3,
  parameter int DB_CYCLES     = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  typedef enum logic [2:0] {
    RELEASED   = 3'd0,
    PRESS_DB   = 3'd1,
    PRESSED    = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  // Complete per-button FSM state; g_btn[i].fsm_q is the observation point.
  typedef struct packed {
    state_t           state;
    logic             from_repeat;
    logic [CNT_W-1:0] cnt;
  } fsm_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [NUM_BTN-1:0] sync_1, sync_2;

  always_ff @(posedge clock) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    fsm_t fsm_q, fsm_d;
    logic level_q, level_d, long_q, long_d;
    logic press_q, press_d, release_q, release_d;
    logic s, en;

    assign s  = sync_2[i];
    assign en = repeat_en[i];

    always_ff @(posedge clock) begin
      if (rst) begin
        fsm_q.state       <= RELEASED;
        fsm_q.from_repeat <= 1'b0;
        fsm_q.cnt         <= '0;
        level_q           <= 1'b0;
        long_q            <= 1'b0;
        press_q           <= 1'b0;
        release_q         <= 1'b0;
      end else begin
        fsm_q     <= fsm_d;
        level_q   <= level_d;
        long_q    <= long_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    always_comb begin
      fsm_d     = fsm_q;
      level_d   = level_q;
      long_d    = long_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (fsm_q.state)
        RELEASED: begin
          fsm_d.cnt = '0;
          if (s) fsm_d.state = PRESS_DB;
        end
        PRESS_DB: begin
          if (!s) begin
            fsm_d.state = RELEASED;
            fsm_d.cnt   = '0;
          end else if (fsm_q.cnt == DB_LAST) begin
            fsm_d.state = PRESSED;
            fsm_d.cnt   = '0;
            level_d     = 1'b1;
            press_d     = 1'b1;
          end else begin
            fsm_d.cnt = fsm_q.cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            fsm_d.state       = RELEASE_DB;
            fsm_d.cnt         = '0;
            fsm_d.from_repeat = 1'b0;
          end else if (fsm_q.cnt == HOLD_LAST) begin
            // Counter parks here once long-press is reached, so enabling
            // repeat later starts repeating on the next cycle.
            long_d = 1'b1;
            if (en) begin
              press_d     = 1'b1;
              fsm_d.state = REPEAT;
              fsm_d.cnt   = '0;
            end
          end else begin
            fsm_d.cnt = fsm_q.cnt + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!s) begin
            fsm_d.state       = RELEASE_DB;
            fsm_d.cnt         = '0;
            fsm_d.from_repeat = 1'b1;
          end else if (!en) begin
            fsm_d.state = PRESSED;
            fsm_d.cnt   = HOLD_LAST;
          end else if (fsm_q.cnt == REP_LAST) begin
            press_d   = 1'b1;
            fsm_d.cnt = '0;
          end else begin
            fsm_d.cnt = fsm_q.cnt + CNT_ONE;
          end
        end
        RELEASE_DB: begin
          if (s) begin
            fsm_d.state = fsm_q.from_repeat ? REPEAT : PRESSED;
            fsm_d.cnt   = (!fsm_q.from_repeat && long_q) ? HOLD_LAST : '0;
          end else if (fsm_q.cnt == DB_LAST) begin
            fsm_d.state = RELEASED;
            fsm_d.cnt   = '0;
            level_d     = 1'b0;
            long_d      = 1'b0;
            release_d   = 1'b1;
          end else begin
            fsm_d.cnt = fsm_q.cnt + CNT_ONE;
          end
        end
        default: begin
          fsm_d.state = RELEASED;
          fsm_d.cnt   = '0;
        end
      endcase
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// every cycle compared against an event-level reference model.
module tb_button_conditioner;
  localparam int NB    = 3;
  localparam int DB    = 4;
  localparam int HOLD  = 20;
  localparam int REP   = 5;
  localparam int CNT_W = 8;
  localparam int W     = 4 * NB;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst;
  logic [NB-1:0] btn_raw, repeat_en;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

  always #5 clock = ~clock;

  button_conditioner #(
    .NUM_BTN(NB), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long)
  );

  // ---------------- checking ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce = DB+1 consecutive synchronized samples disagreeing with the
  // accepted level; hold/repeat measured in edges since the (re)start point.
  bit m_d1[NB], m_d2[NB], m_lvl[NB], m_lng[NB], m_rep[NB];
  int m_run[NB], m_hold[NB], m_rept[NB];
  bit model_live = 0;
  logic [W-1:0] exp_q[$];

  task automatic model_step();
    logic [NB-1:0] lv, pr, rl, lg;
    bit s;
    pr = '0;
    rl = '0;
    for (int b = 0; b < NB; b++) begin
      if (rst) begin
        m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_lng[b] = 0; m_rep[b] = 0;
        m_run[b] = 0; m_hold[b] = 0; m_rept[b] = 0;
      end else begin
        s = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = btn_raw[b];
        if (!m_lvl[b]) begin
          if (s) begin
            m_run[b]++;
            if (m_run[b] == DB + 1) begin
              m_lvl[b] = 1; pr[b] = 1; m_run[b] = 0;
              m_hold[b] = 0; m_lng[b] = 0; m_rep[b] = 0;
            end
          end else m_run[b] = 0;
        end else if (!s) begin
          m_run[b]++;
          if (m_run[b] == DB + 1) begin
            m_lvl[b] = 0; rl[b] = 1; m_run[b] = 0; m_lng[b] = 0; m_rep[b] = 0;
          end
        end else if (m_run[b] > 0) begin
          m_run[b] = 0;
          m_rept[b] = 0;
          if (!m_lng[b]) m_hold[b] = 0;
        end else if (!m_lng[b]) begin
          m_hold[b]++;
          if (m_hold[b] == HOLD) begin
            m_lng[b] = 1;
            if (repeat_en[b]) begin pr[b] = 1; m_rep[b] = 1; m_rept[b] = 0; end
          end
        end else if (m_rep[b]) begin
          if (!repeat_en[b]) m_rep[b] = 0;
          else begin
            m_rept[b]++;
            if (m_rept[b] == REP) begin pr[b] = 1; m_rept[b] = 0; end
          end
        end else if (repeat_en[b]) begin
          pr[b] = 1; m_rep[b] = 1; m_rept[b] = 0;
        end
      end
      lv[b] = m_lvl[b];
      lg[b] = m_lng[b];
    end
    exp_q.push_back({lv, pr, rl, lg});
  endtask

  // ---------------- scoreboard / monitor ----------------
  int edge_cnt = 0;
  int t0 = 0;
  int log_b = 0;
  int p_cyc[$];
  int r_cyc[$];
  int long_first = -1;
  int long_at_rel = -1;
  int lvl_seen = 0;

  always begin
    int idx;
    logic [W-1:0] e;
    @(posedge clock);
    idx = edge_cnt;
    edge_cnt++;
    if (rst) model_live = 1;
    if (model_live) model_step();
    #1;
    if (model_live && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("level",   32'(btn_level),   32'(e[4*NB-1:3*NB]));
      check("press",   32'(btn_press),   32'(e[3*NB-1:2*NB]));
      check("release", 32'(btn_release), 32'(e[2*NB-1:NB]));
      check("long",    32'(btn_long),    32'(e[NB-1:0]));
      if (btn_press[log_b])   p_cyc.push_back(idx + 1 - t0);
      if (btn_release[log_b]) begin
        r_cyc.push_back(idx + 1 - t0);
        long_at_rel = int'(btn_long[log_b]);
      end
      if (btn_long[log_b] && long_first < 0) long_first = idx + 1 - t0;
      if (btn_level[log_b]) lvl_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_test(input int b);
    log_b = b;
    p_cyc.delete();
    r_cyc.delete();
    long_first = -1;
    long_at_rel = -1;
    lvl_seen = 0;
    t0 = edge_cnt;
  endtask

  task automatic drive(input logic [NB-1:0] raw, input logic [NB-1:0] en, input int n);
    btn_raw = raw;
    repeat_en = en;
    repeat (n) @(negedge clock);
  endtask

  task automatic idle();
    drive('0, '0, 25);
  endtask

  task automatic held_test(input bit en, output int n_before);
    start_test(0);
    drive(3'b001, {2'b00, en}, 45);
    drive(3'b000, {2'b00, en}, 25);
    n_before = 0;
    foreach (p_cyc[i]) if (p_cyc[i] < 45) n_before++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int exp_rep[5];
    rst = 1'b1;
    btn_raw = '0;
    repeat_en = '0;
    repeat (3) @(negedge clock);
    check("reset_level", 32'(btn_level), 0);
    check("reset_press", 32'(btn_press), 0);
    rst = 1'b0;
    idle();

    // Clean tap
    start_test(0);
    drive(3'b001, '0, 12);
    drive(3'b000, '0, 20);
    check("tap_npress", p_cyc.size(), 1);
    if (p_cyc.size() > 0) check("tap_press_cyc", p_cyc[0], 7);
    check("tap_nrel", r_cyc.size(), 1);
    if (r_cyc.size() > 0) check("tap_rel_cyc", r_cyc[0], 19);
    check("tap_level_cycles", lvl_seen, 12);
    idle();

    // Bounce rejection
    start_test(1);
    for (int i = 0; i < 40; i++) drive({1'b0, (i % 4) < 2, 1'b0}, '0, 1);
    idle();
    check("bounce_npress", p_cyc.size(), 0);
    check("bounce_nrel", r_cyc.size(), 0);
    check("bounce_level", lvl_seen, 0);

    // Auto-repeat
    exp_rep = '{7, 27, 32, 37, 42};
    held_test(1'b1, n);
    check("rep_npress", n, 5);
    for (int i = 0; i < 5; i++)
      if (i < p_cyc.size()) check("rep_press_cyc", p_cyc[i], exp_rep[i]);
    check("rep_long_first", long_first, 27);
    check("rep_nrel", r_cyc.size(), 1);
    idle();

    // Long press without repeat
    held_test(1'b0, n);
    check("long_npress", p_cyc.size(), 1);
    check("long_first", long_first, 27);
    check("long_nrel", r_cyc.size(), 1);
    check("long_at_rel", long_at_rel, 0);
    idle();

    // Release glitch
    start_test(0);
    drive(3'b001, '0, 12);
    drive(3'b000, '0, 2);
    drive(3'b001, '0, 10);
    drive(3'b000, '0, 20);
    check("glitch_npress", p_cyc.size(), 1);
    check("glitch_nrel", r_cyc.size(), 1);
    if (r_cyc.size() > 0) check("glitch_rel_cyc", r_cyc[0], 24 + DB + 3);
    idle();

    // Reset mid-hold, button 0 busy alongside
    start_test(2);
    for (int c = 0; c < 30; c++) begin
      btn_raw = {1'b1, 1'b0, 1'($urandom_range(0, 1))};
      rst = (c == 15);
      if (c == 15) begin
        @(posedge clock);
        #1;
        check("rst_outputs", 32'({btn_level, btn_press, btn_release, btn_long}), 0);
      end
      @(negedge clock);
    end
    rst = 1'b0;
    check("rst_nrel", r_cyc.size(), 0);
    check("rst_npress", p_cyc.size(), 2);
    if (p_cyc.size() > 1) check("rst_repress_cyc", p_cyc[1], 23);
    idle();

    // Random activity on all buttons, occasional reset
    for (int seg = 0; seg < 150; seg++) begin
      rst = ($urandom_range(0, 24) == 0);
      drive(NB'($urandom), NB'($urandom), 1);
      rst = 1'b0;
      drive(btn_raw ^ NB'($urandom_range(0, 7) == 0 ? $urandom : 0),
            ($urandom_range(0, 3) == 0) ? NB'($urandom) : repeat_en,
            $urandom_range(1, 40));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
